// File: rtl/ppu_vram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ppu_vram_ctrl
// Purpose  : PPU-bus VRAM controller. Latches the multiplexed AD address on
//            ALE, decodes nametable ($2000-$3EFF) and palette ($3F00-$3FFF)
//            space, applies run-time mirroring and serves strobed reads and
//            writes. A read is detected in cycle N and ad_oe rises in N+2.
// Ports    : masterClk   - system clock, rising edge
//            rst         - synchronous active-high reset
//            ad_in       - AD bus in (low address while ale=1, else wr data)
//            addr_hi     - PPU A8-A13
//            ale         - address latch enable
//            rd_n, wr_n  - active-low strobes, sampled on masterClk
//            mirror_mode - 0 horiz, 1 vert, 2 single A, 3 single B, 4 four
//            mode_wr     - load mirror_mode into the mode register
//            ad_out      - read data
//            ad_oe       - drive enable for ad_out
//            hit_nt      - latched address decodes to nametable space
//            hit_pal     - latched address decodes to palette space
// Options  : define FOUR_SCREEN_EN to enable four-screen mode (needs
//            NT_BANKS=4); otherwise two banks are built and mode 4 acts as
//            vertical.
// Revision : 1.0 - initial release
// ============================================================================
module ppu_vram_ctrl #(
    parameter int DATA_W     = 8,
    parameter int NT_BANKS   = 2,
    parameter int PAL_W      = 6,
    parameter int MIRROR_RST = 1
) (
    input  logic              masterClk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ad_in,
    input  logic [5:0]        addr_hi,
    input  logic              ale,
    input  logic              rd_n,
    input  logic              wr_n,
    input  logic [2:0]        mirror_mode,
    input  logic              mode_wr,
    output logic [DATA_W-1:0] ad_out,
    output logic              ad_oe,
    output logic              hit_nt,
    output logic              hit_pal
);

`ifdef FOUR_SCREEN_EN
    localparam int BANKS = NT_BANKS;
    generate
        if (NT_BANKS != 4) begin : g_bank_check
            $error("ppu_vram_ctrl: FOUR_SCREEN_EN requires NT_BANKS=4");
        end
    endgenerate
`else
    // Without four-screen support only two banks are ever addressable.
    localparam int BANKS = 2;
    generate
        if (NT_BANKS != 2 && NT_BANKS != 4) begin : g_bank_check
            $error("ppu_vram_ctrl: NT_BANKS must be 2 or 4");
        end
    endgenerate
`endif

    localparam int BANK_W = (BANKS == 4) ? 2 : 1;
    localparam int NT_AW  = BANK_W + 10;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RD_ISSUE = 2'd1;
    localparam logic [1:0] S_RD_DRIVE = 2'd2;

    // ------------------------------------------------------------------
    // Storage (not reset)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] nt_mem  [0:BANKS*1024-1];
    logic [PAL_W-1:0]  pal_mem [0:31];

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [13:0]      addr_q;
    logic [2:0]       mode_q;
    logic             rd_n_q;
    logic             wr_n_q;
    logic [1:0]       state_q;
    logic             acc_pal_q;
    logic [NT_AW-1:0] acc_nt_idx_q;
    logic [4:0]       acc_pal_idx_q;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic              rd_fall;
    logic              wr_fall;
    logic              hit;
    logic              nt_dec;
    logic              pal_dec;
    logic [BANK_W-1:0] cur_bank;
    logic [NT_AW-1:0]  cur_nt_idx;
    logic [4:0]        cur_pal_idx;
    logic [1:0]        state_d;
    logic              wr_en;
    logic              acc_start;
    logic              rd_en;
    logic              oe_d;
    logic [DATA_W-1:0] pal_rd_ext;

    function automatic logic [BANK_W-1:0] bank_of(input logic [2:0] mode,
                                                  input logic [1:0] a11_10);
        logic [BANK_W-1:0] b;
        case (mode)
            3'd0:    b = BANK_W'(a11_10[1]);
            3'd1:    b = BANK_W'(a11_10[0]);
            3'd2:    b = BANK_W'(1'b0);
            3'd3:    b = BANK_W'(1'b1);
`ifdef FOUR_SCREEN_EN
            3'd4:    b = BANK_W'(a11_10);
`endif
            default: b = BANK_W'(a11_10[0]);   // vertical fallback
        endcase
        return b;
    endfunction

    // Palette entries 0x10/0x14/0x18/0x1C share storage with 0x00..0x0C.
    function automatic logic [4:0] pal_alias(input logic [4:0] i);
        logic [4:0] r;
        r = i;
        if (i[4] && (i[1:0] == 2'b00)) begin
            r[4] = 1'b0;
        end
        return r;
    endfunction

    assign rd_fall     = rd_n_q & ~rd_n;
    assign wr_fall     = wr_n_q & ~wr_n;
    assign hit         = hit_nt | hit_pal;
    assign pal_dec     = (addr_q[13:8] == 6'h3F);
    assign nt_dec      = addr_q[13] & ~pal_dec;
    assign cur_bank    = bank_of(mode_q, addr_q[11:10]);
    assign cur_nt_idx  = {cur_bank, addr_q[9:0]};
    assign cur_pal_idx = pal_alias(addr_q[4:0]);

    always_comb begin
        pal_rd_ext = '0;
        pal_rd_ext[PAL_W-1:0] = pal_mem[acc_pal_idx_q];
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge masterClk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // A simultaneous write wins; the read is dropped.
                if (!wr_fall && rd_fall && hit) begin
                    state_d = S_RD_ISSUE;
                end
            end
            S_RD_ISSUE: begin
                state_d = ale ? S_IDLE : S_RD_DRIVE;
            end
            S_RD_DRIVE: begin
                if (ale || rd_n) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs / strobes
    // ------------------------------------------------------------------
    always_comb begin
        wr_en     = 1'b0;
        acc_start = 1'b0;
        rd_en     = 1'b0;
        oe_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                wr_en     = wr_fall & hit;
                acc_start = ~wr_fall & rd_fall & hit;
            end
            S_RD_ISSUE: begin
                rd_en = ~ale;
            end
            default: ;
        endcase
        oe_d = (state_d == S_RD_DRIVE);
    end

    // ------------------------------------------------------------------
    // Address latch, decode flags, mode register, strobe history
    // ------------------------------------------------------------------
    always_ff @(posedge masterClk) begin
        if (rst) begin
            addr_q  <= '0;
            hit_nt  <= 1'b0;
            hit_pal <= 1'b0;
            mode_q  <= 3'(MIRROR_RST);
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
        end else begin
            if (ale) begin
                addr_q <= {addr_hi, ad_in[7:0]};
            end
            hit_nt  <= nt_dec;
            hit_pal <= pal_dec;
            if (mode_wr) begin
                mode_q <= mirror_mode;
            end
            rd_n_q <= rd_n;
            wr_n_q <= wr_n;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline: access target is frozen at the strobe edge so a later
    // mode or address change cannot redirect an access in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge masterClk) begin
        if (rst) begin
            acc_pal_q     <= 1'b0;
            acc_nt_idx_q  <= '0;
            acc_pal_idx_q <= '0;
            ad_out        <= '0;
            ad_oe         <= 1'b0;
        end else begin
            if (acc_start) begin
                acc_pal_q     <= hit_pal;
                acc_nt_idx_q  <= cur_nt_idx;
                acc_pal_idx_q <= cur_pal_idx;
            end
            if (rd_en) begin
                ad_out <= acc_pal_q ? pal_rd_ext : nt_mem[acc_nt_idx_q];
            end
            ad_oe <= oe_d;
        end
    end

    // ------------------------------------------------------------------
    // RAM write port
    // ------------------------------------------------------------------
    always_ff @(posedge masterClk) begin
        if (wr_en && !rst) begin
            if (hit_pal) begin
                pal_mem[cur_pal_idx] <= ad_in[PAL_W-1:0];
            end else begin
                nt_mem[cur_nt_idx] <= ad_in;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ppu_vram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppu_vram_ctrl
// Purpose  : Self-checking bench for ppu_vram_ctrl: directed scenarios plus
//            randomized accesses against a memory-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ppu_vram_ctrl;

    localparam int MIRROR_RST = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ad_in = '0;
    logic [5:0] addr_hi = '0;
    logic       ale = 1'b0;
    logic       rd_n = 1'b1;
    logic       wr_n = 1'b1;
    logic [2:0] mirror_mode = '0;
    logic       mode_wr = 1'b0;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       hit_nt;
    logic       hit_pal;

    int total = 0;
    int bad   = 0;

    // Reference model: up to four 1 KiB banks plus 32 palette entries.
    logic [7:0] nt_m  [4][1024];
    bit         nt_v  [4][1024];
    logic [7:0] pal_m [32];
    bit         pal_v [32];
    int         m_mode = MIRROR_RST;

    ppu_vram_ctrl #(
        .DATA_W(8), .NT_BANKS(4), .PAL_W(6), .MIRROR_RST(MIRROR_RST)
    ) dut (
        .masterClk(clk), .rst(rst), .ad_in(ad_in), .addr_hi(addr_hi),
        .ale(ale), .rd_n(rd_n), .wr_n(wr_n), .mirror_mode(mirror_mode),
        .mode_wr(mode_wr), .ad_out(ad_out), .ad_oe(ad_oe),
        .hit_nt(hit_nt), .hit_pal(hit_pal)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Which physical bank a nametable address lands in for a given mode.
    function automatic int m_bank(input int mode, input logic [13:0] a);
        case (mode)
            0: return int'(a[11]);
            1: return int'(a[10]);
            2: return 0;
            3: return 1;
`ifdef FOUR_SCREEN_EN
            4: return int'(a[11:10]);
`endif
            default: return int'(a[10]);
        endcase
    endfunction

    function automatic int m_pal_idx(input logic [13:0] a);
        int i;
        i = int'(a) % 32;
        if (i >= 16 && (i % 4) == 0) i -= 16;
        return i;
    endfunction

    function automatic bit is_pal(input logic [13:0] a);
        return a >= 14'h3F00;
    endfunction

    function automatic bit is_nt(input logic [13:0] a);
        return (a >= 14'h2000) && (a < 14'h3F00);
    endfunction

    task automatic set_mode(input int m);
        mirror_mode = 3'(m);
        mode_wr = 1'b1;
        @(negedge clk);
        mode_wr = 1'b0;
        m_mode = m;
    endtask

    task automatic set_addr(input logic [13:0] a);
        ale = 1'b1;
        ad_in = a[7:0];
        addr_hi = a[13:8];
        @(negedge clk);
        ale = 1'b0;
        @(negedge clk);
        check("hit_nt", hit_nt, is_nt(a));
        check("hit_pal", hit_pal, is_pal(a));
    endtask

    task automatic model_write(input logic [13:0] a, input logic [7:0] d);
        int b;
        int p;
        if (is_nt(a)) begin
            b = m_bank(m_mode, a);
            nt_m[b][int'(a[9:0])] = d;
            nt_v[b][int'(a[9:0])] = 1'b1;
        end else if (is_pal(a)) begin
            p = m_pal_idx(a);
            pal_m[p] = d & 8'h3F;
            pal_v[p] = 1'b1;
        end
    endtask

    task automatic do_write(input logic [13:0] a, input logic [7:0] d);
        set_addr(a);
        ad_in = d;
        wr_n = 1'b0;
        @(negedge clk);
        wr_n = 1'b1;
        @(negedge clk);
        model_write(a, d);
    endtask

    task automatic do_read(input string tag, input logic [13:0] a);
        bit         h;
        bit         v;
        logic [7:0] e;
        int         b;
        h = is_nt(a) || is_pal(a);
        v = 1'b0;
        e = '0;
        if (is_nt(a)) begin
            b = m_bank(m_mode, a);
            v = nt_v[b][int'(a[9:0])];
            e = nt_m[b][int'(a[9:0])];
        end else if (is_pal(a)) begin
            v = pal_v[m_pal_idx(a)];
            e = pal_m[m_pal_idx(a)];
        end
        set_addr(a);
        rd_n = 1'b0;
        @(negedge clk);
        check({tag, "_oe_n1"}, ad_oe, 1'b0);
        @(negedge clk);
        check({tag, "_oe_n2"}, ad_oe, h);
        if (h && v) check({tag, "_data"}, ad_out, e);
        @(negedge clk);
        check({tag, "_oe_hold"}, ad_oe, h);
        rd_n = 1'b1;
        @(negedge clk);
        check({tag, "_oe_rel"}, ad_oe, 1'b0);
    endtask

    initial begin
        logic [13:0] a;
        logic [7:0]  d;
        int          r;

        foreach (nt_v[i, j]) nt_v[i][j] = 1'b0;
        foreach (pal_v[i]) pal_v[i] = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_oe", ad_oe, 1'b0);
        check("rst_out", ad_out, 8'h00);
        check("rst_hnt", hit_nt, 1'b0);
        check("rst_hpal", hit_pal, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Vertical (reset mode): $2805 aliases $2005, $2405 is the other bank
        do_write(14'h2405, 8'h11);
        do_write(14'h2005, 8'hA5);
        do_read("vert_2805", 14'h2805);
        do_read("vert_2405", 14'h2405);

        // Horizontal
        set_mode(0);
        do_write(14'h2010, 8'h3C);
        do_write(14'h2C10, 8'h99);
        do_read("horz_2410", 14'h2410);
        do_read("horz_2810", 14'h2810);

        // Palette aliasing and width truncation
        do_write(14'h3F10, 8'h2F);
        do_read("pal_alias", 14'h3F00);
        do_write(14'h3F01, 8'hFF);
        do_read("pal_trunc", 14'h3F01);
        do_read("pal_mirror", 14'h3F21);

        // Cartridge space: no response, no RAM change
        do_write(14'h2100, 8'h42);
        do_read("cart_rd", 14'h1234);
        do_write(14'h0100, 8'hEE);
        do_read("cart_wr", 14'h2100);

        // Simultaneous rd/wr falls: write wins, read dropped
        set_addr(14'h2000);
        ad_in = 8'h77;
        rd_n = 1'b0;
        wr_n = 1'b0;
        @(negedge clk);
        check("simul_oe1", ad_oe, 1'b0);
        @(negedge clk);
        check("simul_oe2", ad_oe, 1'b0);
        rd_n = 1'b1;
        wr_n = 1'b1;
        @(negedge clk);
        check("simul_oe3", ad_oe, 1'b0);
        model_write(14'h2000, 8'h77);
        do_read("simul_rd", 14'h2000);

        // ALE during drive aborts the access
        set_addr(14'h2000);
        rd_n = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_pre", ad_oe, 1'b1);
        ale = 1'b1;
        @(negedge clk);
        check("abort_oe", ad_oe, 1'b0);
        ale = 1'b0;
        @(negedge clk);
        check("abort_stay", ad_oe, 1'b0);
        rd_n = 1'b1;
        @(negedge clk);

        // Mode change during an access does not redirect it
        set_mode(1);
        do_write(14'h2400, 8'hB1);
        do_write(14'h2000, 8'hB0);
        set_addr(14'h2400);
        rd_n = 1'b0;
        mirror_mode = 3'd2;
        mode_wr = 1'b0;
        @(negedge clk);
        mode_wr = 1'b1;
        @(negedge clk);
        mode_wr = 1'b0;
        m_mode = 2;
        check("modechg_oe", ad_oe, 1'b1);
        check("modechg_data", ad_out, 8'hB1);
        rd_n = 1'b1;
        @(negedge clk);

        // Mode 4: four-screen when enabled, vertical otherwise
        set_mode(4);
        do_write(14'h2000, 8'h01);
        do_read("m4_2800_first", 14'h2800);
        do_write(14'h2400, 8'h02);
        do_write(14'h2800, 8'h03);
        do_write(14'h2C00, 8'h04);
        do_read("m4_2000", 14'h2000);
        do_read("m4_2400", 14'h2400);
        do_read("m4_2800", 14'h2800);
        do_read("m4_2C00", 14'h2C00);

        // Reset in the middle of a read
        set_addr(14'h2000);
        rd_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rstmid_pre", ad_oe, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_oe", ad_oe, 1'b0);
        check("rstmid_hnt", hit_nt, 1'b0);
        rst = 1'b0;
        rd_n = 1'b1;
        m_mode = MIRROR_RST;
        @(negedge clk);
        check("rstmid_after", ad_oe, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 7) == 0) set_mode(int'($urandom_range(0, 7)));
            r = int'($urandom_range(0, 7));
            if (r == 0)      a = 14'($urandom_range(0, 14'h1FFF));
            else if (r < 6)  a = 14'(14'h2000 + $urandom_range(0, 14'h1EFF));
            else             a = 14'(14'h3F00 + $urandom_range(0, 8'hFF));
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 0) do_write(a, d);
            else do_read("rnd", a);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
